// File: rtl/multdiv_controller_if.sv
// multdiv_controller_if
// Bus between the multiply/divide sequencer and the multi-cycle arithmetic unit.
//   ctrl_MULT / ctrl_DIV      : one-cycle start pulses (sequencer -> unit)
//   md_operandA / md_operandB : latched operands (sequencer -> unit)
//   md_result                 : unit result (unit -> sequencer)
//   md_resultRDY              : result valid (unit -> sequencer)
//   md_exception              : exception flag, qualified by md_resultRDY (unit -> sequencer)
// Modports: master = sequencer side, slave = arithmetic unit side.
interface multdiv_controller_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic [31:0] md_result;
  logic        md_resultRDY;
  logic        md_exception;

  modport master (
    output ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
    input  md_result, md_resultRDY, md_exception
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
    output md_result, md_resultRDY, md_exception
  );
endinterface

// File: rtl/multdiv_controller.sv
// multdiv_controller
// Sequencer for the multi-cycle multiply/divide unit in the execute stage.
// Detects a mult/div in DX, freezes the front of the pipeline, fires a one-cycle
// start pulse with latched operands, waits for the unit, then releases the
// pipeline for one cycle while presenting result, destination and exception.
//
// Ports:
//   clock, reset        : pipeline clock, synchronous active-high reset
//   ex_valid            : DX holds a real instruction
//   isMult, isDiv       : decoded op type in DX
//   dataA, dataB        : bypassed operands
//   rd                  : destination register of the DX instruction
//   mdBus               : master side of the arithmetic unit bus
//   stall               : freeze PC/FD/DX, bubble into XM
//   result_valid        : one-cycle strobe qualifying result/result_rd/exception
//   result, result_rd   : captured result and destination
//   exception           : captured exception flag
//
// Optional feature: define MULTDIV_TIMEOUT_EN to enable a BUSY-cycle watchdog
// that aborts after TIMEOUT_CYCLES with exception = 1 and result = 0.
module multdiv_controller #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ex_valid,
  input  logic                        isMult,
  input  logic                        isDiv,
  input  logic [31:0]                 dataA,
  input  logic [31:0]                 dataB,
  input  logic [4:0]                  rd,
  multdiv_controller_if.master        mdBus,
  output logic                        stall,
  output logic                        result_valid,
  output logic [31:0]                 result,
  output logic [4:0]                  result_rd,
  output logic                        exception
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  // The watchdog counter is 6 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 63) begin : gBadTimeout
    $error("multdiv_controller: TIMEOUT_CYCLES must be in 2..63");
  end

  stateT       state;
  logic        pulseCycle;
  logic [4:0]  rdLatch;
  logic        start;

`ifdef MULTDIV_TIMEOUT_EN
  localparam logic [5:0] TIMEOUT_LIMIT = 6'(TIMEOUT_CYCLES);
  logic [5:0]  busyCount;
`endif

  // Both decode flags high is a malformed decode and must not start the unit.
  assign start = ex_valid & (isMult ^ isDiv);

  // Stall is combinational in IDLE so the triggering instruction is frozen in
  // the same cycle it is detected; BUSY holds the freeze until the result lands.
  always_comb begin
    stall = 1'b0;
    if (state == BUSY) begin
      stall = 1'b1;
    end else if (state == IDLE) begin
      stall = start;
    end
  end

  // Single sequencing process. Start pulses and result_valid default low each
  // cycle so they are naturally one cycle wide. pulseCycle marks the first BUSY
  // cycle, where a ready flag left over from a previous operation is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      pulseCycle        <= 1'b0;
      rdLatch           <= 5'd0;
      mdBus.ctrl_MULT   <= 1'b0;
      mdBus.ctrl_DIV    <= 1'b0;
      mdBus.md_operandA <= 32'd0;
      mdBus.md_operandB <= 32'd0;
      result_valid      <= 1'b0;
      result            <= 32'd0;
      result_rd         <= 5'd0;
      exception         <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      busyCount         <= 6'd0;
`endif
    end else begin
      mdBus.ctrl_MULT <= 1'b0;
      mdBus.ctrl_DIV  <= 1'b0;
      result_valid    <= 1'b0;
      pulseCycle      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state             <= BUSY;
            pulseCycle        <= 1'b1;
            mdBus.md_operandA <= dataA;
            mdBus.md_operandB <= dataB;
            rdLatch           <= rd;
            mdBus.ctrl_MULT   <= isMult;
            mdBus.ctrl_DIV    <= isDiv;
`ifdef MULTDIV_TIMEOUT_EN
            busyCount         <= 6'd0;
`endif
          end
        end
        BUSY: begin
`ifdef MULTDIV_TIMEOUT_EN
          busyCount <= busyCount + 6'd1;
`endif
          if (!pulseCycle && mdBus.md_resultRDY) begin
            state        <= DONE;
            result_valid <= 1'b1;
            result       <= mdBus.md_exception ? 32'd0 : mdBus.md_result;
            exception    <= mdBus.md_exception;
            result_rd    <= rdLatch;
          end
`ifdef MULTDIV_TIMEOUT_EN
          // busyCount counts earlier BUSY cycles, so +1 includes this one.
          else if (busyCount + 6'd1 == TIMEOUT_LIMIT) begin
            state        <= DONE;
            result_valid <= 1'b1;
            result       <= 32'd0;
            exception    <= 1'b1;
            result_rd    <= rdLatch;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
